// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-field widths, MULT/DIV latency,
// forwarding select codes and the hazard-control output bundle.
package pipeline_pkg;

    localparam int          REG_W              = 5;
    localparam logic [4:0]  REG_ZERO           = 5'd0;
    localparam int          MULDIV_LAT_DEFAULT = 4;

    // Forwarding mux selects, shared with the forwarding unit.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    // Per-cycle pipeline steering decided by the hazard controller.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic muldiv_start;
    } hazard_ctl_t;

    // Normal flow: everything advances, nothing squashed, no MULT/DIV issue.
    localparam hazard_ctl_t CTL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
        id_ex_flush: 1'b0, muldiv_start: 1'b0
    };

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ID/EX hazard information from the pipeline and the steering signals back.
interface pipeline_hazard_controller_if;
    import pipeline_pkg::*;

    logic [REG_W-1:0] IF_ID_rs;
    logic [REG_W-1:0] IF_ID_rt;
    logic             ID_uses_rt;
    logic             ID_is_muldiv;
    logic             ID_reads_hilo;
    logic             ID_EX_MemRead;
    logic [REG_W-1:0] ID_EX_rt;
    logic             branch_taken;

    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             muldiv_start;
    logic             muldiv_busy;

    // Pipeline side: reports stage contents, obeys the steering signals.
    modport master (
        output IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_is_muldiv, ID_reads_hilo,
               ID_EX_MemRead, ID_EX_rt, branch_taken,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               muldiv_start, muldiv_busy
    );

    // Hazard controller side.
    modport slave (
        input  IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_is_muldiv, ID_reads_hilo,
               ID_EX_MemRead, ID_EX_rt, branch_taken,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               muldiv_start, muldiv_busy
    );

endinterface

// File: rtl/pipeline_hazard_controller_muldiv_busy_counter.sv
// Down-counter modelling how many more cycles the MULT/DIV unit is busy.
module muldiv_busy_counter #(
    parameter int LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic [3:0] remaining
);

    logic [3:0] md_cnt;

    // Load on issue, otherwise count down to zero; an in-flight op is never squashed.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, matching the hardware.
        if (rst) begin
            md_cnt <= 4'd0;
        end else if (start) begin
            md_cnt <= 4'(LAT);
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    assign busy      = (md_cnt != 4'd0);
    assign remaining = md_cnt;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: load-use and HI/LO hazard detection, branch squash
// priority, MULT/DIV busy tracking and a saturating stall-cycle counter.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_controller_if.slave bus,
    output logic [CNT_W-1:0]     stall_cycles
);

    logic        load_use;
    logic        hilo_wait;
    logic        stall;
    logic        md_busy;
    logic [3:0]  md_remaining;
    hazard_ctl_t ctl;

    muldiv_busy_counter #(
        .LAT (MULDIV_LAT)
    ) u_muldiv_busy_counter (
        .clk       (clk),
        .rst       (rst),
        .start     (ctl.muldiv_start),
        .busy      (md_busy),
        .remaining (md_remaining)
    );

    // Hazard decode: a load into $zero never creates a dependency.
    always_comb begin
        load_use  = bus.ID_EX_MemRead && (bus.ID_EX_rt != REG_ZERO) &&
                    ((bus.ID_EX_rt == bus.IF_ID_rs) ||
                     (bus.ID_uses_rt && (bus.ID_EX_rt == bus.IF_ID_rt)));
        hilo_wait = (md_remaining != 4'd0) && (bus.ID_reads_hilo || bus.ID_is_muldiv);
        stall     = (load_use || hilo_wait) && !bus.branch_taken;
    end

    // Priority mux: a taken branch is older than ID and overrides any stall.
    always_comb begin
        // NOTE: default every field first so no path leaves ctl unassigned,
        // which would infer a latch.
        ctl = CTL_RUN;
        if (bus.branch_taken) begin
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end else if (stall) begin
            ctl.pc_write    = 1'b0;
            ctl.if_id_write = 1'b0;
            ctl.id_ex_flush = 1'b1;
        end else begin
            ctl.muldiv_start = bus.ID_is_muldiv;
        end
    end

    assign bus.PC_write     = ctl.pc_write;
    assign bus.IF_ID_write  = ctl.if_id_write;
    assign bus.IF_ID_flush  = ctl.if_id_flush;
    assign bus.ID_EX_flush  = ctl.id_ex_flush;
    assign bus.muldiv_start = ctl.muldiv_start;
    assign bus.muldiv_busy  = md_busy;

    // Count stall cycles only (flush-only cycles excluded), saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
